// File: rtl/serv_ls_seq.sv
// serv_ls_seq: phase sequencer for the bit-serial buffer register.
// Runs one load, store or shift at a time through init shift-in, a bus
// cycle or shift countdown, and write-back. It drives the buffer strobes
// and the Wishbone handshake.
module serv_ls_seq (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [1:0] i_op,
    input  logic [1:0] i_lsb,
    input  logic [1:0] i_size,
    input  logic       i_sh_done,
    input  logic       i_wb_ack,
    output logic       o_busy,
    output logic       o_init,
    output logic       o_en,
    output logic [4:0] o_cnt,
    output logic       o_cnt_done,
    output logic       o_byte_valid,
    output logic       o_shift_op,
    output logic       o_load,
    output logic       o_wb_cyc,
    output logic       o_wb_we,
    output logic [3:0] o_wb_sel,
    output logic       o_ext,
    output logic       o_misalign,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_BUS,
        S_SHIFT,
        S_RUN
    } state_t;

    localparam logic [1:0] OP_STORE    = 2'd0;
    localparam logic [1:0] OP_LOAD     = 2'd1;
    localparam logic [1:0] OP_SHIFT    = 2'd2;
    localparam logic [1:0] OP_RESERVED = 2'd3;

    state_t     r_state;
    logic [4:0] r_cnt;
    logic [1:0] r_op;
    logic [1:0] r_lsb;
    logic [1:0] r_size;
    logic       r_wb_cyc;
    logic       r_wb_we;
    logic [3:0] r_wb_sel;
    logic       r_misalign;
    // Set for the single cycle in which a rejected or no-op request reports
    // completion. Starts are held off in that cycle, just as they are while
    // a real operation finishes.
    logic       r_nop_done;

    logic       w_accept;
    logic       w_mem_op;
    logic       w_misaligned;
    logic       w_cnt_last;
    logic       w_store_done;
    logic       w_run_done;
    logic [6:0] w_ext_from;

    // Byte-lane enables for an access of the given size at the given offset.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'd0:    lane_sel = 4'b0001 << lsb;
            2'd1:    lane_sel = 4'b0011 << lsb;
            2'd2:    lane_sel = 4'hF;
            default: lane_sel = 4'h0;
        endcase
    endfunction

    assign w_accept     = (r_state == S_IDLE) && i_start && !r_nop_done;
    assign w_mem_op     = (i_op == OP_STORE) || (i_op == OP_LOAD);
    assign w_misaligned = w_mem_op &&
                          (((i_size == 2'd1) && i_lsb[0]) ||
                           ((i_size == 2'd2) && (i_lsb != 2'd0)) ||
                           (i_size == 2'd3));
    assign w_cnt_last   = (r_cnt == 5'd31);

    // Phase sequencing, bus handshake registers and operand latching.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_op       <= 2'd0;
            r_lsb      <= 2'd0;
            r_size     <= 2'd0;
            r_wb_cyc   <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_sel   <= 4'h0;
            r_misalign <= 1'b0;
            r_nop_done <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all of them update from
            // pre-edge values; a blocking = would leak new values into later
            // statements of the same edge.
            r_misalign <= 1'b0;
            r_nop_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= i_op;
                        r_lsb  <= i_lsb;
                        r_size <= i_size;
                        r_cnt  <= 5'd0;
                        if (i_op == OP_RESERVED) begin
                            r_nop_done <= 1'b1;
                        end else if (w_misaligned) begin
                            r_misalign <= 1'b1;
                            r_nop_done <= 1'b1;
                        end else if (i_op == OP_LOAD) begin
                            r_state  <= S_BUS;
                            r_wb_cyc <= 1'b1;
                            r_wb_we  <= 1'b0;
                            r_wb_sel <= lane_sel(i_size, i_lsb);
                        end else begin
                            r_state <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (w_cnt_last) begin
                        r_cnt <= 5'd0;
                        if (r_op == OP_STORE) begin
                            r_state  <= S_BUS;
                            r_wb_cyc <= 1'b1;
                            r_wb_we  <= 1'b1;
                            r_wb_sel <= lane_sel(r_size, r_lsb);
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_BUS: begin
                    if (i_wb_ack) begin
                        r_wb_cyc <= 1'b0;
                        r_wb_we  <= 1'b0;
                        r_wb_sel <= 4'h0;
                        r_cnt    <= 5'd0;
                        r_state  <= (r_op == OP_STORE) ? S_IDLE : S_RUN;
                    end
                end
                S_SHIFT: begin
                    if (i_sh_done) begin
                        r_cnt   <= 5'd0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (w_cnt_last) begin
                        r_cnt   <= 5'd0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 5'd0;
                end
            endcase
        end
    end

    // Completion is flagged in the last cycle of an operation.
    assign w_store_done = (r_state == S_BUS) && i_wb_ack && (r_op == OP_STORE);
    assign w_run_done   = (r_state == S_RUN) && w_cnt_last;

    // Extension starts at the first bit past the access width (8, 16 or 32).
    assign w_ext_from = 7'd8 << r_size;

    // Buffer shift qualifier and sign/zero extension window.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned,
        // which would otherwise infer a latch.
        o_byte_valid = 1'b0;
        o_ext        = 1'b0;
        if ((r_state == S_INIT) && (r_op == OP_STORE)) begin
            // Skip the top lsb bytes so the data lands at byte offset lsb.
            o_byte_valid = ({1'b0, r_cnt[4:3]} + {1'b0, r_lsb}) < 3'd4;
        end
        if ((r_state == S_RUN) && (r_op == OP_LOAD)) begin
            o_byte_valid = 1'b1;
            o_ext        = {2'b00, r_cnt} >= w_ext_from;
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_init     = (r_state == S_INIT);
    assign o_en       = (r_state == S_INIT) || (r_state == S_RUN);
    assign o_cnt      = r_cnt;
    assign o_cnt_done = o_en && w_cnt_last;
    assign o_shift_op = (r_op == OP_SHIFT) && ((r_state == S_INIT) || (r_state == S_SHIFT));
    assign o_load     = i_wb_ack && r_wb_cyc && !r_wb_we;
    assign o_wb_cyc   = r_wb_cyc;
    assign o_wb_we    = r_wb_we;
    assign o_wb_sel   = r_wb_sel;
    assign o_misalign = r_misalign;
    assign o_done     = r_nop_done || w_store_done || w_run_done;

endmodule

// File: tb/tb_serv_ls_seq.sv
// tb_serv_ls_seq: directed bench for serv_ls_seq. Each operation is expanded
// into a per-cycle list of inputs and the outputs that operation must produce.
// A single compare step checks every cycle against that list.
module tb_serv_ls_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start, i_sh_done, i_wb_ack;
    logic [1:0] i_op, i_lsb, i_size;
    logic       o_busy, o_init, o_en, o_cnt_done, o_byte_valid, o_shift_op;
    logic       o_load, o_wb_cyc, o_wb_we, o_ext, o_misalign, o_done;
    logic [4:0] o_cnt;
    logic [3:0] o_wb_sel;

    int checks = 0;
    int errors = 0;

    // Per-operation tallies of DUT activity, used for the literal pins.
    int n_bv, n_ext, n_done, n_load, n_mis, n_cyc, n_shop, n_sel_bad;

    always #5 clk = ~clk;

    serv_ls_seq dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (i_start),
        .i_op         (i_op),
        .i_lsb        (i_lsb),
        .i_size       (i_size),
        .i_sh_done    (i_sh_done),
        .i_wb_ack     (i_wb_ack),
        .o_busy       (o_busy),
        .o_init       (o_init),
        .o_en         (o_en),
        .o_cnt        (o_cnt),
        .o_cnt_done   (o_cnt_done),
        .o_byte_valid (o_byte_valid),
        .o_shift_op   (o_shift_op),
        .o_load       (o_load),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_we      (o_wb_we),
        .o_wb_sel     (o_wb_sel),
        .o_ext        (o_ext),
        .o_misalign   (o_misalign),
        .o_done       (o_done)
    );

    typedef struct {
        logic       start, ack, sh_done;
        logic       busy, init, en, cnt_done, bv, shift_op, load, cyc, we, ext, misalign, done;
        logic [4:0] cnt;
        logic [3:0] sel;
    } cyc_t;

    cyc_t q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cyc_t blank(input logic start);
        cyc_t c;
        c = '{default: '0};
        c.start = start;
        return c;
    endfunction

    // Expand one request into its expected cycle-by-cycle trace.
    // op: 0 store, 1 load, 2 shift, 3 reserved. n_wait: BUS cycles before ack.
    // n_sh: cycles spent in SHIFT. hold: keep i_start high throughout.
    task automatic build_txn(input int op, input int lsb, input int size,
                             input int n_wait, input int n_sh, input bit hold);
        cyc_t c;
        bit   mis;
        int   sel;
        mis = (op < 2) && ((size == 1 && (lsb % 2) == 1) || (size == 2 && lsb != 0) || size == 3);
        c = blank(1'b1);
        q.push_back(c);
        if (op == 3 || mis) begin
            c = blank(hold);
            c.done = 1'b1;
            c.misalign = mis;
            q.push_back(c);
            return;
        end
        sel = (size == 0) ? (1 << lsb) : (size == 1) ? (3 << lsb) : 15;
        if (op == 0 || op == 2) begin
            for (int k = 0; k < 32; k++) begin
                c = blank(hold);
                c.busy = 1'b1; c.init = 1'b1; c.en = 1'b1;
                c.cnt = 5'(k); c.cnt_done = (k == 31);
                c.bv = (op == 0) && ((k / 8) < (4 - lsb));
                c.shift_op = (op == 2);
                q.push_back(c);
            end
        end
        if (op < 2) begin
            for (int w = 0; w <= n_wait; w++) begin
                c = blank(hold);
                c.busy = 1'b1; c.cyc = 1'b1; c.we = (op == 0); c.sel = 4'(sel);
                if (w == n_wait) begin
                    c.ack = 1'b1; c.load = (op == 1); c.done = (op == 0);
                end
                q.push_back(c);
            end
        end
        if (op == 2) begin
            for (int s = 0; s < n_sh; s++) begin
                c = blank(hold);
                c.busy = 1'b1; c.shift_op = 1'b1; c.sh_done = (s == n_sh - 1);
                q.push_back(c);
            end
        end
        if (op >= 1) begin
            for (int k = 0; k < 32; k++) begin
                c = blank(hold);
                c.busy = 1'b1; c.en = 1'b1;
                c.cnt = 5'(k); c.cnt_done = (k == 31);
                c.bv = (op == 1);
                c.ext = (op == 1) && (k >= 8 * (1 << size));
                c.done = (k == 31);
                q.push_back(c);
            end
        end
    endtask

    task automatic compare(input cyc_t c);
        check("busy",       int'(o_busy),       int'(c.busy));
        check("init",       int'(o_init),       int'(c.init));
        check("en",         int'(o_en),         int'(c.en));
        check("cnt",        int'(o_cnt),        int'(c.cnt));
        check("cnt_done",   int'(o_cnt_done),   int'(c.cnt_done));
        check("byte_valid", int'(o_byte_valid), int'(c.bv));
        check("shift_op",   int'(o_shift_op),   int'(c.shift_op));
        check("load",       int'(o_load),       int'(c.load));
        check("wb_cyc",     int'(o_wb_cyc),     int'(c.cyc));
        check("wb_we",      int'(o_wb_we),      int'(c.we));
        check("wb_sel",     int'(o_wb_sel),     int'(c.sel));
        check("ext",        int'(o_ext),        int'(c.ext));
        check("misalign",   int'(o_misalign),   int'(c.misalign));
        check("done",       int'(o_done),       int'(c.done));
        n_bv   += int'(o_byte_valid);
        n_ext  += int'(o_ext);
        n_done += int'(o_done);
        n_load += int'(o_load);
        n_mis  += int'(o_misalign);
        n_cyc  += int'(o_wb_cyc);
        n_shop += int'(o_shift_op);
        if (o_wb_cyc && (o_wb_sel != c.sel)) n_sel_bad++;
    endtask

    task automatic clear_tallies();
        n_bv = 0; n_ext = 0; n_done = 0; n_load = 0;
        n_mis = 0; n_cyc = 0; n_shop = 0; n_sel_bad = 0;
    endtask

    // Play up to 'limit' queued cycles: drive inputs, check at the falling
    // edge. With 'stop_at_neg' the last cycle ends at that falling edge.
    task automatic play(input int limit, input bit stop_at_neg);
        cyc_t c;
        int   n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            c = q.pop_front();
            i_start   = c.start;
            i_wb_ack  = c.ack;
            i_sh_done = c.sh_done;
            @(negedge clk);
            compare(c);
            n++;
            if (!(stop_at_neg && (n == limit || q.size() == 0))) begin
                @(posedge clk);
                #1;
            end
        end
        i_start   = 1'b0;
        i_wb_ack  = 1'b0;
        i_sh_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   int'(o_busy),   0);
        check({tag, "_en"},     int'(o_en),     0);
        check({tag, "_cnt"},    int'(o_cnt),    0);
        check({tag, "_wb_cyc"}, int'(o_wb_cyc), 0);
        check({tag, "_wb_sel"}, int'(o_wb_sel), 0);
        check({tag, "_done"},   int'(o_done),   0);
        check({tag, "_load"},   int'(o_load),   0);
    endtask

    // Set the operand inputs that the next request will present.
    task automatic set_req(input int op, input int lsb, input int size);
        i_op   = 2'(op);
        i_lsb  = 2'(lsb);
        i_size = 2'(size);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_start = 1'b0; i_sh_done = 1'b0; i_wb_ack = 1'b0;
        i_op = 2'd0; i_lsb = 2'd0; i_size = 2'd0;
        #23;
        check_all_zero("reset");
        #4;
        rst = 1'b0;

        // Stray acknowledges while idle must be ignored.
        clear_tallies();
        for (int i = 0; i < 3; i++) begin
            q.push_back(blank(1'b0));
            q[q.size() - 1].ack = 1'b1;
        end
        play(3, 1'b0);
        check("stray_ack_load", n_load, 0);
        check("stray_ack_done", n_done, 0);

        // Store byte at lsb 2, ack on the third BUS cycle.
        clear_tallies();
        set_req(0, 2, 0);
        build_txn(0, 2, 0, 2, 0, 1'b0);
        check("model_store_len", q.size(), 36);
        play(1000, 1'b0);
        check("store_bv_cycles", n_bv, 16);
        check("store_cyc_cycles", n_cyc, 3);
        check("store_done_count", n_done, 1);

        // Load half at lsb 2, ack on the first BUS cycle.
        clear_tallies();
        set_req(1, 2, 1);
        build_txn(1, 2, 1, 0, 0, 1'b0);
        check("model_load_sel", int'(q[1].sel), 12);
        play(1000, 1'b0);
        check("load_ext_cycles", n_ext, 16);
        check("load_pulse_count", n_load, 1);
        check("load_done_count", n_done, 1);
        check("load_sel_stable", n_sel_bad, 0);

        // Misaligned word at lsb 1, then misaligned half at lsb 3.
        clear_tallies();
        set_req(1, 1, 2);
        build_txn(1, 1, 2, 0, 0, 1'b0);
        play(1000, 1'b0);
        set_req(0, 3, 1);
        build_txn(0, 3, 1, 0, 0, 1'b0);
        play(1000, 1'b0);
        check("misalign_pulses", n_mis, 2);
        check("misalign_done", n_done, 2);
        check("misalign_no_cyc", n_cyc, 0);

        // Shift: sh_done rises five cycles after SHIFT entry.
        clear_tallies();
        set_req(2, 0, 0);
        build_txn(2, 0, 0, 0, 6, 1'b0);
        check("model_shift_len", q.size(), 71);
        play(1000, 1'b0);
        check("shift_op_cycles", n_shop, 38);
        check("shift_done_count", n_done, 1);

        // Shift whose countdown is already done on SHIFT entry.
        set_req(2, 1, 2);
        build_txn(2, 1, 2, 0, 1, 1'b0);
        play(1000, 1'b0);

        // Back-to-back with start held high: operand inputs stay constant
        // for the whole stream, so each request is built from the same
        // operands and the held start is ignored while busy.
        clear_tallies();
        set_req(0, 0, 2);
        build_txn(0, 0, 2, 1, 0, 1'b1);
        build_txn(0, 0, 2, 0, 0, 1'b1);
        play(1000, 1'b0);
        check("b2b_store_done", n_done, 2);
        clear_tallies();
        set_req(3, 0, 0);
        build_txn(3, 0, 0, 0, 0, 1'b1);
        build_txn(3, 0, 0, 0, 0, 1'b1);
        build_txn(3, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) q.push_back(blank(1'b0));
        play(1000, 1'b0);
        check("b2b_nop_done", n_done, 3);
        check("b2b_nop_no_misalign", n_mis, 0);
        clear_tallies();
        set_req(1, 3, 0);
        build_txn(1, 3, 0, 1, 0, 1'b1);
        build_txn(1, 3, 0, 0, 0, 1'b0);
        play(1000, 1'b0);
        check("b2b_load_ext", n_ext, 48);

        // Reset mid-BUS: cyc must drop without a clock edge.
        set_req(1, 0, 2);
        build_txn(1, 0, 2, 5, 0, 1'b0);
        play(3, 1'b1);
        check("pre_rst_cyc", int'(o_wb_cyc), 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_mid_bus");
        q.delete();
        @(posedge clk);
        #2 rst = 1'b0;

        // Reset mid-INIT: counter returns to zero.
        set_req(0, 0, 2);
        build_txn(0, 0, 2, 0, 0, 1'b0);
        play(10, 1'b1);
        check("pre_rst_cnt", int'(o_cnt), 8);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_mid_init");
        q.delete();
        @(posedge clk);
        #2 rst = 1'b0;

        // Operation right after reset, then quiet idle cycles.
        clear_tallies();
        set_req(1, 0, 0);
        build_txn(1, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 2; i++) q.push_back(blank(1'b0));
        play(1000, 1'b0);
        check("post_rst_load_done", n_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
